// File: rtl/branch_predict_ctrl.sv
// Front-end branch prediction controller: direct-mapped BTB with 2-bit counters,
// EX-stage resolution, registered PC redirect with one-cycle pipeline flush.
module branch_predict_ctrl #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            flush_ex,
  output logic [XLEN-1:0] branch_count,
  output logic [XLEN-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t                 state_q, state_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d;
  logic [XLEN-1:0]        target_d;
  logic [1:0]             ctr_d;
  logic                   btb_we;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]        branch_count_q, branch_count_d;
  logic [XLEN-1:0]        mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             is_jump, resolve, actual_taken, mispredict;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // Lookup reads the array state before any same-cycle update lands.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_valid && if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

  assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign is_jump      = ex_is_jal || ex_is_jalr;
  assign resolve      = ex_valid && !ex_stall && (state_q == IDLE) &&
                        (ex_is_branch || is_jump);
  assign actual_taken = is_jump || (ex_is_branch && ex_branch_taken);
  assign mispredict   = (actual_taken != ex_pred_taken) ||
                        (actual_taken && ex_pred_taken &&
                         (ex_branch_target != ex_pred_target));

  always_comb begin
    state_d            = IDLE;
    valid_d            = valid_q;
    btb_we             = 1'b0;
    tag_d              = ex_tag;
    target_d           = ex_branch_target;
    ctr_d              = ctr_q[ex_idx];
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve) begin
      branch_count_d = branch_count_q + XLEN'(1);
      if (actual_taken) begin
        btb_we          = 1'b1;
        valid_d[ex_idx] = 1'b1;
        if (is_jump)
          ctr_d = 2'd3;
        else if (ex_hit)
          ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
        else
          ctr_d = 2'd2;
      end else if (ex_hit) begin
        btb_we   = 1'b1;
        target_d = target_q[ex_idx];
        ctr_d    = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
      end
      if (mispredict) begin
        mispredict_count_d = mispredict_count_q + XLEN'(1);
        state_d            = REDIRECT;
        redirect_valid_d   = 1'b1;
        redirect_pc_d      = actual_taken ? ex_branch_target : ex_pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      valid_q            <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      valid_q            <= valid_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_q[ex_idx]    <= tag_d;
      target_q[ex_idx] <= target_d;
      ctr_q[ex_idx]    <= ctr_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign flush_if_id      = redirect_valid_q;
  assign flush_id_ex      = redirect_valid_q;
  assign flush_ex         = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios plus a
// randomized run against a table-level BTB/redirect reference model.
module tb_branch_predict_ctrl;

  localparam int XLEN = 32;
  localparam int NENT = 16;
  localparam int TAG_SHIFT = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [XLEN-1:0] ex_pc, ex_pred_target, ex_branch_target;
  logic            ex_pred_taken, ex_branch_taken;
  logic            redirect_valid, flush_if_id, flush_id_ex, flush_ex;
  logic [XLEN-1:0] redirect_pc, branch_count, mispredict_count;

  int tests_run = 0;
  int tests_failed = 0;

  bit          m_valid [NENT];
  logic [31:0] m_pc    [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  bit          m_redirect;
  logic [31:0] m_rpc;
  logic [31:0] m_bcnt, m_mcnt;

  branch_predict_ctrl #(.XLEN(XLEN), .BTB_ENTRIES(NENT)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex(flush_ex),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // The model keys each entry by the full PC that allocated it.
  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic bit model_hit(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && ((m_pc[i] >> TAG_SHIFT) == (pc >> TAG_SHIFT));
  endfunction

  function automatic bit model_pred_taken(bit v, logic [31:0] pc);
    return v && model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_pred_target(bit v, logic [31:0] pc);
    return model_pred_taken(v, pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    m_redirect = 1'b0;
    m_rpc  = '0;
    m_bcnt = '0;
    m_mcnt = '0;
  endfunction

  function automatic void model_clock();
    bit taken, mis, jump, h;
    int i;
    if (rst) return;
    if (m_redirect) begin
      m_redirect = 1'b0;
      return;
    end
    if (!(ex_valid && !ex_stall && (ex_is_branch || ex_is_jal || ex_is_jalr))) return;
    jump  = ex_is_jal || ex_is_jalr;
    taken = jump || (ex_is_branch && ex_branch_taken);
    mis   = (taken != ex_pred_taken) ||
            (taken && ex_pred_taken && ex_branch_target != ex_pred_target);
    m_bcnt = m_bcnt + 1;
    i = idx_of(ex_pc);
    h = model_hit(ex_pc);
    if (taken) begin
      if (h) m_ctr[i] = jump ? 3 : ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1);
      else begin
        m_valid[i] = 1'b1;
        m_pc[i]    = ex_pc;
        m_ctr[i]   = jump ? 3 : 2;
      end
      m_tgt[i] = ex_branch_target;
    end else if (h) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end
    if (mis) begin
      m_mcnt = m_mcnt + 1;
      m_redirect = 1'b1;
      m_rpc = taken ? ex_branch_target : ex_pc + 32'd4;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive_ex(bit v, bit br, bit jal, bit jalr, logic [31:0] pc,
                          bit pt, logic [31:0] ptg, bit bt, logic [31:0] btg);
    ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_pc = pc; ex_pred_taken = pt; ex_pred_target = ptg;
    ex_branch_taken = bt; ex_branch_target = btg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_valid = 1'b1; if_pc = 32'h100;
    ex_stall = 1'b0;
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if_id, flush_id_ex, flush_ex} !== 4'b0 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got rv/flush=%b rpc=%h expected 0", {redirect_valid, flush_if_id, flush_id_ex, flush_ex}, redirect_pc);
    end
    tests_run++;
    if (branch_count !== 32'h0 || mispredict_count !== 32'h0 || pred_taken !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counts: got bc=%0d mc=%0d pt=%b expected 0", branch_count, mispredict_count, pred_taken);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_mispredict();
    logic [31:0] bc0 = m_bcnt, mc0 = m_mcnt;
    if_valid = 1'b1; if_pc = 32'h100;
    drive_ex(1, 1, 0, 0, 32'h100, 0, 32'h0, 1, 32'h180);
    @(negedge clk);
    tests_run++;
    if (pred_taken !== 1'b0 || redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cold_before: got pt=%b rv=%b expected 0 0", pred_taken, redirect_valid);
    end
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if_id, flush_id_ex, flush_ex} !== 4'b1111 || redirect_pc !== 32'h180) begin
      tests_failed++;
      $display("[TB] FAIL cold_redirect: got rv/flush=%b rpc=%h expected 1111 00000180", {redirect_valid, flush_if_id, flush_id_ex, flush_ex}, redirect_pc);
    end
    tests_run++;
    if (mispredict_count !== mc0 + 1 || branch_count !== bc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL cold_counts: got bc=%0d mc=%0d expected %0d %0d", branch_count, mispredict_count, bc0 + 1, mc0 + 1);
    end
    tests_run++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin
      tests_failed++;
      $display("[TB] FAIL cold_trained: got pt=%b tgt=%h expected 1 00000180", pred_taken, pred_target);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if_id, flush_id_ex, flush_ex} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL cold_one_cycle: got rv/flush=%b expected 0000", {redirect_valid, flush_if_id, flush_id_ex, flush_ex});
    end
  endtask

  task automatic test_training();
    if_valid = 1'b1; if_pc = 32'h100;
    for (int k = 0; k < 2; k++) begin
      drive_ex(1, 1, 0, 0, 32'h100, 1, 32'h180, 1, 32'h180);
      tick();
      drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tests_run++;
      if (redirect_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL train_no_redirect: got rv=%b expected 0 (iter %0d)", redirect_valid, k);
      end
    end
    drive_ex(1, 1, 0, 0, 32'h100, 1, 32'h180, 0, 32'h180);
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
      tests_failed++;
      $display("[TB] FAIL train_nt_redirect: got rv=%b rpc=%h expected 1 00000104", redirect_valid, redirect_pc);
    end
    tests_run++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h180) begin
      tests_failed++;
      $display("[TB] FAIL train_still_taken: got pt=%b tgt=%h expected 1 00000180", pred_taken, pred_target);
    end
    tick();
    // Second not-taken drops the saturated counter 3->2->1: prediction flips.
    drive_ex(1, 1, 0, 0, 32'h100, 1, 32'h180, 0, 32'h180);
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      tests_failed++;
      $display("[TB] FAIL train_weak_nt: got pt=%b tgt=%h expected 0 00000104", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_jalr_target();
    if_valid = 1'b1; if_pc = 32'h200;
    drive_ex(1, 0, 0, 1, 32'h200, 1, 32'h300, 0, 32'h340);
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h340) begin
      tests_failed++;
      $display("[TB] FAIL jalr_redirect: got rv=%b rpc=%h expected 1 00000340", redirect_valid, redirect_pc);
    end
    tests_run++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h340) begin
      tests_failed++;
      $display("[TB] FAIL jalr_btb_target: got pt=%b tgt=%h expected 1 00000340", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] bc0 = m_bcnt, mc0 = m_mcnt;
    if_valid = 1'b0; if_pc = 32'h300;
    drive_ex(1, 1, 0, 0, 32'h300, 0, 32'h0, 1, 32'h380);
    tick();
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h380) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got rv=%b rpc=%h expected 1 00000380", redirect_valid, redirect_pc);
    end
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b0 || branch_count !== bc0 + 1 || mispredict_count !== mc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ignored: got rv=%b bc=%0d mc=%0d expected 0 %0d %0d", redirect_valid, branch_count, mispredict_count, bc0 + 1, mc0 + 1);
    end
    drive_ex(1, 1, 0, 0, 32'h300, 1, 32'h380, 0, 32'h380);
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || branch_count !== bc0 + 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_next_normal: got rv=%b rpc=%h bc=%0d expected 1 00000304 %0d", redirect_valid, redirect_pc, branch_count, bc0 + 2);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] bc0 = m_bcnt, mc0 = m_mcnt;
    drive_ex(1, 1, 0, 0, 32'h440, 0, 32'h0, 1, 32'h4c0);
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      tests_run++;
      if (redirect_valid !== 1'b0 || branch_count !== bc0 || mispredict_count !== mc0) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold: got rv=%b bc=%0d mc=%0d expected 0 %0d %0d (cycle %0d)", redirect_valid, branch_count, mispredict_count, bc0, mc0, k);
      end
    end
    ex_stall = 1'b0;
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4c0 || branch_count !== bc0 + 1 || mispredict_count !== mc0 + 1) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got rv=%b rpc=%h bc=%0d mc=%0d expected 1 000004c0 %0d %0d", redirect_valid, redirect_pc, branch_count, mispredict_count, bc0 + 1, mc0 + 1);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_single: got rv=%b expected 0", redirect_valid);
    end
  endtask

  task automatic test_reset_mid_redirect();
    if_valid = 1'b1; if_pc = 32'h100;
    drive_ex(1, 1, 0, 0, 32'h100, 0, 32'h0, 1, 32'h180);
    tick();
    drive_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (redirect_valid !== 1'b1 || pred_taken !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_setup: got rv=%b pt=%b expected 1 1", redirect_valid, pred_taken);
    end
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if ({redirect_valid, flush_if_id, flush_id_ex, flush_ex} !== 4'b0 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_outputs: got rv/flush=%b rpc=%h expected 0", {redirect_valid, flush_if_id, flush_id_ex, flush_ex}, redirect_pc);
    end
    tests_run++;
    if (branch_count !== 32'h0 || mispredict_count !== 32'h0 || pred_taken !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_state: got bc=%0d mc=%0d pt=%b expected 0 0 0", branch_count, mispredict_count, pred_taken);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'h100, 32'h140, 32'h104, 32'h200, 32'h3c0, 32'h1000};
    logic [31:0] e_tgt;
    bit e_pt;
    int kind;
    for (int c = 0; c < 400; c++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc = ($urandom_range(0, 5) == 0) ? ($urandom() & 32'hffff_fffc) : pool[$urandom_range(0, 5)];
      ex_valid = ($urandom_range(0, 4) != 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      kind = $urandom_range(0, 6);
      ex_is_branch = (kind <= 3);
      ex_is_jal = (kind == 4);
      ex_is_jalr = (kind == 5);
      ex_pc = pool[$urandom_range(0, 5)];
      ex_branch_taken = $urandom_range(0, 1);
      ex_branch_target = pool[$urandom_range(0, 5)] + 32'h80;
      if ($urandom_range(0, 2) != 0) begin
        ex_pred_taken = model_pred_taken(1'b1, ex_pc);
        ex_pred_target = model_pred_target(1'b1, ex_pc);
      end else begin
        ex_pred_taken = $urandom_range(0, 1);
        ex_pred_target = pool[$urandom_range(0, 5)] + 32'h80;
      end
      @(negedge clk);
      e_pt = model_pred_taken(if_valid, if_pc);
      e_tgt = model_pred_target(if_valid, if_pc);
      tests_run++;
      if (pred_taken !== e_pt || pred_target !== e_tgt) begin
        tests_failed++;
        $display("[TB] FAIL rand_predict: cycle %0d pc=%h got pt=%b tgt=%h expected %b %h", c, if_pc, pred_taken, pred_target, e_pt, e_tgt);
      end
      tests_run++;
      if ({redirect_valid, flush_if_id, flush_id_ex, flush_ex} !== {4{m_redirect}} ||
          (m_redirect && redirect_pc !== m_rpc)) begin
        tests_failed++;
        $display("[TB] FAIL rand_redirect: cycle %0d got rv/flush=%b rpc=%h expected %b %h", c, {redirect_valid, flush_if_id, flush_id_ex, flush_ex}, redirect_pc, {4{m_redirect}}, m_rpc);
      end
      tests_run++;
      if (branch_count !== m_bcnt || mispredict_count !== m_mcnt) begin
        tests_failed++;
        $display("[TB] FAIL rand_counts: cycle %0d got bc=%0d mc=%0d expected %0d %0d", c, branch_count, mispredict_count, m_bcnt, m_mcnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cold_mispredict();
    test_training();
    test_jalr_target();
    test_back_to_back();
    test_stall();
    test_reset_mid_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
